// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the
// RSA-256 Montgomery multiplier datapath.
package rsa_pkg;

  localparam int RSA_W = 256;
  localparam int ADD_W = 258;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL,
    DONE
  } state_e;

endpackage

// File: rtl/csa258.sv
// 258-bit carry-skip adder: 43 ripple blocks of 6 bits,
// each bypassing its ripple chain when fully propagating.
module csa258
  import rsa_pkg::*;
(
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [ADD_W-1:0] sum_o,
  output logic             cout_o
);

  localparam int BLK = 6;
  localparam int NB  = ADD_W / BLK;

  logic c;
  logic c_blk;
  logic prop;
  logic p;

  always_comb begin
    c     = cin_i;
    c_blk = 1'b0;
    prop  = 1'b0;
    p     = 1'b0;
    sum_o = '0;
    for (int k = 0; k < NB; k++) begin
      c_blk = c;
      prop  = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        p = a_i[k*BLK+j] ^ b_i[k*BLK+j];
        sum_o[k*BLK+j] = p ^ c;
        c = (a_i[k*BLK+j] & b_i[k*BLK+j]) | (p & c);
        prop = prop & p;
      end
      // all-propagate block passes its carry-in straight through
      if (prop) c = c_blk;
    end
    cout_o = c;
  end

endmodule

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, plus the final
// conditional-subtract compare sharing adder 0.
module mont_step
  import rsa_pkg::*;
(
  input  logic [ADD_W-1:0] s_i,
  input  logic             a_bit_i,
  input  logic [RSA_W-1:0] b_i,
  input  logic [RSA_W-1:0] n_i,
  input  logic             fin_i,
  output logic [ADD_W-1:0] s_o,
  output logic [RSA_W-1:0] diff_o,
  output logic             ge_o
);

  logic [ADD_W-1:0] b0;
  logic             cin0;
  logic [ADD_W-1:0] t;
  logic             c0;
  logic [ADD_W-1:0] b1;
  logic [ADD_W-1:0] u;
  logic             c1;
  logic             unused_bits;

  // FINAL reuses adder 0 as S - N via ~N + 1
  always_comb begin
    b0   = '0;
    cin0 = 1'b0;
    if (fin_i) begin
      b0   = ~{2'b00, n_i};
      cin0 = 1'b1;
    end else if (a_bit_i) begin
      b0   = {2'b00, b_i};
    end
  end

  csa258 u_add0 (
    .a_i    (s_i),
    .b_i    (b0),
    .cin_i  (cin0),
    .sum_o  (t),
    .cout_o (c0)
  );

  assign b1 = t[0] ? {2'b00, n_i} : '0;

  csa258 u_add1 (
    .a_i    (t),
    .b_i    (b1),
    .cin_i  (1'b0),
    .sum_o  (u),
    .cout_o (c1)
  );

  assign s_o    = {1'b0, u[ADD_W-1:1]};
  assign diff_o = t[RSA_W-1:0];
  assign ge_o   = c0;

  assign unused_bits = ^{c1, u[0], t[ADD_W-1:RSA_W]};

endmodule

// File: rtl/mont_mul256.sv
// Iterative radix-2 Montgomery multiplier, M = A*B*2^-256 mod N,
// one multiplier bit per cycle with a final conditional subtract.
module mont_mul256
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RSA_W-1:0] in_a,
  input  logic [RSA_W-1:0] in_b,
  input  logic [RSA_W-1:0] in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RSA_W-1:0] out_m,
  output logic             busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RSA_W-1:0] a_q;
  logic [RSA_W-1:0] b_q;
  logic [RSA_W-1:0] n_q;
  logic [ADD_W-1:0] s_q;
  logic [RSA_W-1:0] m_q;
  logic             ov_q;

  logic [ADD_W-1:0] s_d;
  logic [RSA_W-1:0] diff;
  logic             ge;

  mont_step u_step (
    .s_i     (s_q),
    .a_bit_i (a_q[cnt_q]),
    .b_i     (b_q),
    .n_i     (n_q),
    .fin_i   (state_q == FINAL),
    .s_o     (s_d),
    .diff_o  (diff),
    .ge_o    (ge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      m_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            n_q     <= in_n;
            s_q     <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q   <= s_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) state_q <= FINAL;
        end
        FINAL: begin
          m_q     <= ge ? diff : s_q[RSA_W-1:0];
          ov_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == FINAL);
  assign out_valid = ov_q;
  assign out_m     = m_q;

endmodule

// File: tb/tb_mont_mul256.sv
// Directed-vector bench for mont_mul256: results, latency,
// handshake, backpressure and mid-run reset.
module tb_mont_mul256;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_a;
  logic [255:0] in_b;
  logic [255:0] in_n;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_m;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mont_mul256 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_m     (out_m),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [255:0] a,
                       input logic [255:0] b,
                       input logic [255:0] n);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_n     = n;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // cycle 1 is the one after the accepting edge
  task automatic wait_done(input bit pulse, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      if (pulse && cyc == 20) begin
        in_valid = 1'b1;
        in_a     = 256'd1;
        in_b     = 256'd1;
        in_n     = 256'd3;
      end
      if (pulse && cyc == 25) begin
        chk("rdy_in_run", {255'd0, in_ready}, 256'd0);
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ov_clr", {255'd0, out_valid}, 256'd0);
    chk("rdy_back", {255'd0, in_ready}, 256'd1);
  endtask

  task automatic run_op(input string tag,
                        input logic [255:0] a,
                        input logic [255:0] b,
                        input logic [255:0] n,
                        input logic [255:0] exp,
                        input bit pulse);
    int cyc;
    start(a, b, n);
    chk({tag, "_busy"}, {255'd0, busy}, 256'd1);
    wait_done(pulse, cyc);
    chk({tag, "_lat"}, 256'(cyc), 256'd258);
    chk({tag, "_m"}, out_m, exp);
    release_out();
  endtask

  logic [255:0] nmax;
  logic [255:0] nhalf;
  int           cyc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_n      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy", {255'd0, in_ready}, 256'd1);
    chk("rst_ov", {255'd0, out_valid}, 256'd0);
    chk("rst_m", out_m, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);

    // 3*5*R^-1 mod 7, R = 2 mod 7, R^-1 = 4
    run_op("t1", 256'd3, 256'd5, 256'd7, 256'd4, 1'b0);
    // 4*1*4 mod 7 = 2
    run_op("t2", 256'd4, 256'd1, 256'd7, 256'd2, 1'b0);

    // N = 2^256-1 gives R = 1 mod N, so (N-1)^2 = 1
    nmax = '1;
    run_op("t3", nmax - 1, nmax - 1, nmax, 256'd1, 1'b0);

    nhalf = '0;
    nhalf[255] = 1'b1;
    nhalf[0]   = 1'b1;
    run_op("t4", 256'd0, nhalf - 1, nhalf, 256'd0, 1'b1);

    // even modulus: value undefined, timing must hold
    start(256'd3, 256'd5, 256'd8);
    wait_done(1'b0, cyc);
    chk("even_lat", 256'(cyc), 256'd258);
    release_out();

    // 5*6*4 = 120 = 1 mod 7, held under backpressure
    start(256'd5, 256'd6, 256'd7);
    wait_done(1'b0, cyc);
    chk("t5_lat", 256'(cyc), 256'd258);
    for (int i = 0; i < 10; i++) begin
      chk("t5_m", out_m, 256'd1);
      chk("t5_ov", {255'd0, out_valid}, 256'd1);
      chk("t5_rdy", {255'd0, in_ready}, 256'd0);
      @(posedge clk);
      #1;
    end
    release_out();

    // reset after the cnt=100 step is registered
    start(256'd3, 256'd5, 256'd7);
    repeat (100) @(posedge clk);
    #1;
    chk("t6_busy", {255'd0, busy}, 256'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rdy", {255'd0, in_ready}, 256'd1);
    chk("t6_ov", {255'd0, out_valid}, 256'd0);
    chk("t6_m", out_m, 256'd0);
    chk("t6_busy0", {255'd0, busy}, 256'd0);
    run_op("t6b", 256'd3, 256'd5, 256'd7, 256'd4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
